// File: rtl/scan_loader.sv
// Serial scan-chain loader/reader: shifts a CELLS-bit pattern into a life array
// MSB first while capturing the array's previous contents into a readback register.
module scan_loader #(
  parameter int CELLS    = 16,
  parameter int SCAN_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             write_mode,
  input  logic [CELLS-1:0] pattern,
  input  logic             scan_read_val,
  output logic             scan,
  output logic             scan_write_val,
  output logic             scan_write_enb,
  output logic             busy,
  output logic             done,
  output logic [CELLS-1:0] readback
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(CELLS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CELLS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_reg;
  logic [CELLS-1:0] psr_reg;
  logic [CELLS-1:0] rb_reg;
  logic             wm_reg;
  logic [DW-1:0]    div_reg;
  logic [CW-1:0]    cnt_reg;
  logic             scan_edge;

  // With SCAN_DIV=1 the divider sits at 0 == DIV_LAST, so scan stays high all of SHIFT.
  assign scan_edge = (state_reg == SHIFT) && (div_reg == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      psr_reg   <= '0;
      rb_reg    <= '0;
      wm_reg    <= 1'b0;
      div_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            psr_reg   <= pattern;
            wm_reg    <= write_mode;
            div_reg   <= '0;
            cnt_reg   <= '0;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          div_reg <= (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
          if (scan_edge) begin
            psr_reg <= {psr_reg[CELLS-2:0], 1'b0};
            rb_reg  <= {rb_reg[CELLS-2:0], scan_read_val};
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == CNT_LAST) state_reg <= DONE;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign scan           = scan_edge;
  assign busy           = (state_reg == SHIFT);
  assign done           = (state_reg == DONE);
  assign scan_write_val = busy ? psr_reg[CELLS-1] : 1'b0;
  assign scan_write_enb = busy ? wm_reg : 1'b0;
  assign readback       = rb_reg;

endmodule

// File: tb/tb_scan_loader.sv
// Bench for scan_loader: two instances (SCAN_DIV=4 and SCAN_DIV=1), each driving a
// behavioural 16-cell recirculating chain; expected images queued at start, checked at done.
module tb_scan_loader;

  localparam int CELLS = 16;

  typedef struct packed {
    logic [CELLS-1:0] rb;
    logic [CELLS-1:0] chain;
  } exp_t;

  logic clk = 1'b0;
  logic reset, start, write_mode, sel;
  logic [CELLS-1:0] pattern;
  logic start_a, start_b;
  logic preload;
  logic [CELLS-1:0] preload_val;

  logic scan_a, wv_a, we_a, busy_a, done_a;
  logic scan_b, wv_b, we_b, busy_b, done_b;
  logic [CELLS-1:0] rb_a, rb_b, chain_a, chain_b;

  logic obs_scan, obs_wv, obs_wenb, obs_busy, obs_done;
  logic [CELLS-1:0] obs_rb, obs_chain;

  int vectors = 0;
  int miscompares = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  scan_loader #(.CELLS(CELLS), .SCAN_DIV(4)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .write_mode(write_mode),
    .pattern(pattern), .scan_read_val(chain_a[CELLS-1]), .scan(scan_a),
    .scan_write_val(wv_a), .scan_write_enb(we_a), .busy(busy_a),
    .done(done_a), .readback(rb_a)
  );

  scan_loader #(.CELLS(CELLS), .SCAN_DIV(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .write_mode(write_mode),
    .pattern(pattern), .scan_read_val(chain_b[CELLS-1]), .scan(scan_b),
    .scan_write_val(wv_b), .scan_write_enb(we_b), .busy(busy_b),
    .done(done_b), .readback(rb_b)
  );

  // Life-array model: cell 0 takes the serial input or recirculates cell CELLS-1.
  always @(posedge clk) begin
    if (preload) begin
      chain_a <= preload_val;
      chain_b <= preload_val;
    end else begin
      if (scan_a) chain_a <= {chain_a[CELLS-2:0], we_a ? wv_a : chain_a[CELLS-1]};
      if (scan_b) chain_b <= {chain_b[CELLS-2:0], we_b ? wv_b : chain_b[CELLS-1]};
    end
  end

  always_comb begin
    obs_scan  = sel ? scan_b  : scan_a;
    obs_wv    = sel ? wv_b    : wv_a;
    obs_wenb  = sel ? we_b    : we_a;
    obs_busy  = sel ? busy_b  : busy_a;
    obs_done  = sel ? done_b  : done_a;
    obs_rb    = sel ? rb_b    : rb_a;
    obs_chain = sel ? chain_b : chain_a;
  end

  task automatic do_preload(input logic [CELLS-1:0] v);
    preload_val = v;
    preload = 1'b1;
    @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
  endtask

  // Called at a negedge with the selected DUT idle; returns at the negedge of its DONE cycle.
  task automatic run_scan(input int div, input bit wm, input logic [CELLS-1:0] pat,
                          input bit hold, input string name);
    exp_t e;
    int n_scan = 0, n_busy = 0, k_done = 0;
    int gap_bad = 0, wenb_bad = 0, wv_bad = 0;
    e.rb    = obs_chain;
    e.chain = wm ? pat : obs_chain;
    sb.push_back(e);
    start = 1'b1;
    write_mode = wm;
    pattern = pat;
    @(posedge clk);
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (obs_busy) n_busy++;
      if (obs_wenb !== (obs_busy ? wm : 1'b0)) wenb_bad++;
      if (!obs_busy && obs_wv !== 1'b0) wv_bad++;
      if (obs_scan) begin
        if (n_scan < CELLS && obs_wv !== pat[CELLS-1-n_scan]) wv_bad++;
        n_scan++;
        if (k != div * n_scan) gap_bad++;
      end
      if (obs_done) begin
        k_done = k;
        break;
      end
    end
    e = sb.pop_front();
    vectors++;
    if (k_done == 0) begin
      miscompares++;
      $display("FAIL %s timeout: no done within 400 cycles", name);
    end
    vectors++;
    if (n_scan !== CELLS) begin
      miscompares++;
      $display("FAIL %s pulses: got %0d want %0d", name, n_scan, CELLS);
    end
    vectors++;
    if (n_busy !== CELLS * div) begin
      miscompares++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, n_busy, CELLS * div);
    end
    vectors++;
    if (k_done !== CELLS * div + 1) begin
      miscompares++;
      $display("FAIL %s done_cycle: got %0d want %0d", name, k_done, CELLS * div + 1);
    end
    vectors++;
    if (gap_bad !== 0 || wenb_bad !== 0 || wv_bad !== 0) begin
      miscompares++;
      $display("FAIL %s strobes: gap_err=%0d wenb_err=%0d wval_err=%0d want 0 0 0",
               name, gap_bad, wenb_bad, wv_bad);
    end
    vectors++;
    if (obs_rb !== e.rb) begin
      miscompares++;
      $display("FAIL %s readback: got %h want %h", name, obs_rb, e.rb);
    end
    vectors++;
    if (obs_chain !== e.chain) begin
      miscompares++;
      $display("FAIL %s chain: got %h want %h", name, obs_chain, e.chain);
    end
    $display("scan %s: wm=%0d pat=%h readback=%h chain=%h done_cycle=%0d",
             name, wm, pat, obs_rb, obs_chain, k_done);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    write_mode = 1'b1;
    pattern = 16'hA5A5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({obs_scan, obs_wv, obs_wenb, obs_busy, obs_done} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {obs_scan, obs_wv, obs_wenb, obs_busy, obs_done});
    end
    vectors++;
    if (obs_rb !== '0) begin
      miscompares++;
      $display("FAIL reset_readback: got %h want 0000", obs_rb);
    end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if (obs_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_priority: busy got %b want 0", obs_busy);
    end
    $display("reset: controls and readback checked");
  endtask

  task automatic test_load();
    do_preload(16'h0000);
    run_scan(4, 1'b1, 16'h33CC, 1'b0, "load");
  endtask

  task automatic test_read_only();
    do_preload(16'h6186);
    run_scan(4, 1'b0, 16'h0F0F, 1'b0, "read_only");
    repeat (10) @(negedge clk);
    vectors++;
    if (obs_rb !== 16'h6186) begin
      miscompares++;
      $display("FAIL readback_hold: got %h want 6186", obs_rb);
    end
  endtask

  task automatic test_back_to_back();
    int extra = 0;
    do_preload(16'h0000);
    run_scan(4, 1'b1, 16'h3300, 1'b0, "b2b_load");
    start = 1'b1;
    write_mode = 1'b0;
    @(negedge clk);
    vectors++;
    if (obs_busy !== 1'b0 || obs_done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle_gap: busy=%b done=%b want 0 0", obs_busy, obs_done);
    end
    run_scan(4, 1'b0, 16'h5555, 1'b1, "b2b_read");
    start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (obs_scan || obs_busy) extra++;
    end
    vectors++;
    if (extra !== 0) begin
      miscompares++;
      $display("FAIL b2b_extra: busy/scan cycles got %0d want 0", extra);
    end
  endtask

  task automatic test_reset_mid_scan();
    int n = 0, dn = 0, bz = 0;
    do_preload(16'h0000);
    start = 1'b1;
    write_mode = 1'b1;
    pattern = 16'h1234;
    @(posedge clk);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (obs_scan) n++;
      if (n == 5 && !obs_scan) break;
    end
    vectors++;
    if (n !== 5) begin
      miscompares++;
      $display("FAIL abort_setup: pulses got %0d want 5", n);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (obs_busy !== 1'b0 || obs_scan !== 1'b0 || obs_rb !== '0 || obs_done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_state: busy=%b scan=%b rb=%h done=%b want 0 0 0000 0",
               obs_busy, obs_scan, obs_rb, obs_done);
    end
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (obs_done) dn++;
      if (obs_busy) bz++;
    end
    vectors++;
    if (dn !== 0 || bz !== 0) begin
      miscompares++;
      $display("FAIL abort_quiet: done=%0d busy=%0d want 0 0", dn, bz);
    end
    $display("abort: partial chain=%h", obs_chain);
    run_scan(4, 1'b1, 16'h0700, 1'b0, "reload");
  endtask

  task automatic test_div1();
    sel = 1'b1;
    do_preload(16'h0000);
    run_scan(1, 1'b1, 16'hFFFF, 1'b0, "div1");
    sel = 1'b0;
  endtask

  initial begin
    sel = 1'b0;
    preload = 1'b0;
    preload_val = '0;
    @(negedge clk);
    test_reset();
    test_load();
    test_read_only();
    test_back_to_back();
    test_reset_mid_scan();
    test_div1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scan_loader.md
SCAN_LOADER -- requirements
Module: scan_loader

Interface
REQ-001 The block SHALL have parameter CELLS, default 16, meaning the scan-chain length in cells (one bit per cell).
REQ-002 The block SHALL have parameter SCAN_DIV, default 4, meaning clocks per scan pulse; legal values are 1 and above.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin one full-chain scan.
REQ-006 The block SHALL have port write_mode, input, 1 bit: 1 = load pattern, 0 = non-destructive read-only scan.
REQ-007 The block SHALL have port pattern, input, CELLS bits: the cell image to load, with bit i destined for cell i.
REQ-008 The block SHALL have port scan_read_val, input, 1 bit: the life array's last-cell output (cell CELLS-1) before the current shift.
REQ-009 The block SHALL have port scan, output, 1 bit: shift strobe to the life array.
REQ-010 The block SHALL have port scan_write_val, output, 1 bit: the serial bit entering cell 0.
REQ-011 The block SHALL have port scan_write_enb, output, 1 bit: 1 = array takes scan_write_val into cell 0; 0 = array recirculates its own output.
REQ-012 The block SHALL have port busy, output, 1 bit: a scan is in progress.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-014 The block SHALL have port readback, output, CELLS bits: the pre-scan array image, with bit i from cell i.

Function
REQ-015 The block SHALL implement three states: IDLE, SHIFT and DONE.
REQ-016 In IDLE, when start=1 is sampled at edge E0, the block SHALL latch pattern into shift register psr, latch write_mode, clear the divider and bit counter, and enter SHIFT.
REQ-017 A start sampled in SHIFT or DONE SHALL be ignored; requests are not queued.
REQ-018 In SHIFT, busy SHALL be 1; in IDLE and DONE, busy SHALL be 0.
REQ-019 The divider SHALL count 0 to SCAN_DIV-1 and wrap; scan SHALL be 1 combinationally in exactly the cycles where divider = SCAN_DIV-1 and state = SHIFT.
REQ-020 With SCAN_DIV=1, scan SHALL be held high for CELLS consecutive cycles.
REQ-021 Scan edges SHALL occur at E0+SCAN_DIV*k for k = 1..CELLS, giving exactly CELLS pulses per scan.
REQ-022 scan_write_val SHALL equal psr[CELLS-1] throughout SHIFT, and 0 otherwise.
REQ-023 On each scan edge, psr SHALL shift left by one bit, with 0 entering the LSB, so the pattern is sent MSB first.
REQ-024 scan_write_enb SHALL equal the latched write_mode during SHIFT, and 0 otherwise.
REQ-025 On each scan edge, the readback shift register SHALL take {rb[CELLS-2:0], scan_read_val}.
REQ-026 After CELLS pulses, rb[i] SHALL hold the pre-scan value of cell i.
REQ-027 The readback output SHALL change only on scan edges; it SHALL hold its value in IDLE and DONE until the next scan.
REQ-028 The bit counter SHALL be wide enough for CELLS, SHALL increment on each scan edge, and on the CELLS-th scan edge the state SHALL go to DONE.
REQ-029 DONE SHALL last exactly one cycle with done=1, then return to IDLE; the earliest next accepted start is in the IDLE cycle that follows.
REQ-030 With defaults, done SHALL be high in the cycle after edge E0+64, and busy SHALL be high for exactly 64 cycles.
REQ-031 With write_mode=0, the array image SHALL be unchanged after a scan, because the array recirculates when scan_write_enb=0, and readback SHALL still be valid.

Reset
REQ-032 When reset=1 at an edge, regardless of state, the block SHALL enter IDLE and clear psr, rb, the divider and the bit counter.
REQ-033 After reset, outputs SHALL be: scan=0, scan_write_val=0, scan_write_enb=0, busy=0, done=0, readback=0.
REQ-034 Reset SHALL take priority over start in the same cycle.
REQ-035 A reset during SHIFT SHALL abort the scan without emitting done; partial array contents are the system's concern.

Verification
REQ-036 Load test: defaults, behavioural 16-cell chain model initially 0x0000, write_mode=1, pattern=0x33CC, start pulse -> exactly 16 scan pulses spaced 4 clocks apart, done after 64 busy cycles, chain = 0x33CC, readback = 0x0000.
REQ-037 Read-only test: chain holds 0x6186, write_mode=0, start -> readback = 0x6186, chain still 0x6186, scan_write_enb=0 throughout.
REQ-038 Back-to-back test: load 0x3300; start held high continuously from DONE onward -> second scan begins only after IDLE is reached, readback = 0x3300, and extra starts during busy produce no further scans.
REQ-039 Reset mid-scan test: reset asserted after 5 scan pulses -> next cycle busy=0, scan=0, readback=0, no done pulse; a subsequent load of 0x0700 completes correctly.
REQ-040 SCAN_DIV=1 test: load 0xFFFF -> scan high for 16 consecutive cycles, done in cycle 17, chain = 0xFFFF.
